// File: rtl/shared_timer_arbiter.sv
// shared_timer_arbiter: one prescaled delay timer shared among NREQ requesters.
// A winner is granted the timer, counts D ticks of a mod-M prescaler, then gets
// a one-cycle done pulse. Build macro SHARED_TIMER_RR_EN selects round-robin
// arbitration. Without it, the lowest requesting index always wins.
module shared_timer_arbiter #(
    parameter int NREQ = 4,
    parameter int M    = 10,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] dly,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic               tick
);
    localparam int IW = $clog2(NREQ);
    localparam int PW = $clog2(M);
    localparam logic [PW-1:0] PMAX = PW'(M - 1);
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_ptr, w_ptr_nxt;
    logic [IW-1:0]   r_owner, w_owner_nxt;
    logic [IW-1:0]   w_win, w_owner_inc;
    logic [PW-1:0]   r_presc, w_presc_nxt;
    logic [DW-1:0]   r_rem, w_rem_nxt, w_win_dly;
    logic [NREQ-1:0] r_grant, w_grant_nxt;
    logic [NREQ-1:0] r_done, w_done_nxt;
    logic            w_tick, w_abort;

    // First set bit of req_v, scanning upward from start with wrap.
    function automatic logic [IW-1:0] f_pick(input logic [NREQ-1:0] req_v,
                                             input logic [IW-1:0]   start);
        logic [IW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(start) + k) % NREQ;
            if (!found && req_v[idx]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [NREQ-1:0] f_onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] idx);
        return (idx == LAST) ? '0 : idx + 1'b1;
    endfunction

    // In fixed-priority builds the pointer never moves, so scanning from it
    // is the same as scanning from index 0.
    assign w_win     = f_pick(req, r_ptr);
    assign w_win_dly = dly[int'(w_win)*DW +: DW];
`ifdef SHARED_TIMER_RR_EN
    assign w_owner_inc = f_inc(r_owner);
`else
    assign w_owner_inc = '0;
`endif

    assign w_tick  = (r_state == S_RUN) && (r_presc == PMAX);
    assign w_abort = (r_state == S_RUN) && !req[r_owner];

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = (r_state != S_IDLE);
    assign tick  = w_tick;

    // Next-state and next-register logic; abort outranks tick completion.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_presc_nxt = r_presc;
        w_rem_nxt   = r_rem;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_owner_nxt = w_win;
                    if (w_win_dly != '0) begin
                        w_state_nxt = S_RUN;
                        w_grant_nxt = f_onehot(w_win);
                        w_rem_nxt   = w_win_dly;
                        w_presc_nxt = '0;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_grant_nxt = '0;
                        w_done_nxt  = f_onehot(w_win);
                    end
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_owner_inc;
                end else begin
                    w_presc_nxt = (r_presc == PMAX) ? '0 : r_presc + 1'b1;
                    if (w_tick) begin
                        if (r_rem == DW'(1)) begin
                            w_state_nxt = S_DONE;
                            w_grant_nxt = '0;
                            w_done_nxt  = f_onehot(r_owner);
                            w_rem_nxt   = '0;
                        end else if (r_rem != '0) begin
                            w_rem_nxt = r_rem - 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = w_owner_inc;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_presc <= '0;
            r_rem   <= '0;
            r_grant <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_presc <= w_presc_nxt;
            r_rem   <= w_rem_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
        end
    end
endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Scoreboard bench for shared_timer_arbiter (NREQ=4, M=10, DW=8).
// Completed jobs are pushed as expectations when requested; a negedge monitor
// pops them on each done pulse and checks owner, grant length and tick count.
module tb_shared_timer_arbiter;
    localparam int NREQ = 4;
    localparam int M    = 10;
    localparam int DW   = 8;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic [NREQ-1:0]  req     = '0;
    logic [NREQ*DW-1:0] dly   = '0;
    logic [NREQ-1:0]  grant, done;
    logic             busy, tick;

    shared_timer_arbiter #(.NREQ(NREQ), .M(M), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .dly(dly),
        .grant(grant), .done(done), .busy(busy), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dv;
        int         d;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_dly(input int i, input int d);
        dly[i*DW +: DW] = 8'(d);
    endtask

    task automatic expect_done(input logic [3:0] dv, input int d, input int gap);
        exp_t e;
        e.dv  = dv;
        e.d   = d;
        e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done != 0) seen = 1'b1;
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    // Monitor: accumulate grant/tick activity per job, compare on done.
    int         gcnt = 0, tcnt = 0, last_done = 0;
    logic [3:0] gv = '0, prev_grant = '0, prev_done = '0;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (!reset_n) begin
            gcnt = 0; tcnt = 0; gv = '0; prev_grant = '0; prev_done = '0;
        end else begin
            if (grant != 0) begin
                gcnt++;
                gv = grant;
            end
            if (tick) tcnt++;
            if (prev_done != 0) chk("done_width", done, 0);
            if (done != 0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_vec", done, mon_e.dv);
                    chk("grant_at_done", grant, 0);
                    chk("grant_cycles", gcnt, mon_e.d * M);
                    chk("tick_count", tcnt, mon_e.d);
                    chk("grant_owner", gv, (mon_e.d == 0) ? 4'b0000 : mon_e.dv);
                    if (mon_e.gap >= 0) chk("done_gap", cyc - last_done, mon_e.gap);
                end
                last_done = cyc;
                gcnt = 0; tcnt = 0; gv = '0;
            end else if (prev_grant != 0 && grant == 0) begin
                gcnt = 0; tcnt = 0; gv = '0;
            end
            prev_grant = grant;
            prev_done  = done;
        end
    end

    logic [3:0] ord [5];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset mid-RUN, then immediate re-grant after release
        set_dly(0, 3);
        req = 4'b0001;
        repeat (12) @(negedge clk);
        chk("mid_grant", grant, 4'b0001);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tick", tick, 0);
        @(negedge clk);
        reset_n = 1'b1;
        expect_done(4'b0001, 3, -1);
        @(negedge clk);
        chk("regrant", grant, 4'b0001);
        wait_done("rst_job", 40);
        req = '0;
        @(negedge clk);
        chk("rst_job_busy_after", busy, 0);
        @(negedge clk);

        // Single request, D=3
        set_dly(2, 3);
        expect_done(4'b0100, 3, -1);
        req = 4'b0100;
        wait_done("single", 40);
        req = '0;
        @(negedge clk);
        chk("single_busy_after", busy, 0);
        chk("single_done_after", done, 0);
        @(negedge clk);

        // Zero delay
        set_dly(1, 0);
        expect_done(4'b0010, 0, -1);
        req = 4'b0010;
        @(negedge clk);
        chk("zero_done", done, 4'b0010);
        chk("zero_grant", grant, 0);
        req = '0;
        @(negedge clk);
        chk("zero_busy_after", busy, 0);
        @(negedge clk);

        // Return the pointer to 0 before contention
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Contention, all four requesting with D=1
`ifdef SHARED_TIMER_RR_EN
        ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        ord = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        for (int i = 0; i < NREQ; i++) set_dly(i, 1);
        for (int k = 0; k < 5; k++) expect_done(ord[k], 1, (k == 0) ? -1 : 12);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_done("contend", 20);
        req = '0;
        repeat (2) @(negedge clk);

        // Abort of requester 3, pending 0 and 1 must resolve to 0
        set_dly(3, 2);
        set_dly(0, 1);
        set_dly(1, 1);
        req = 4'b1000;
        @(negedge clk);
        chk("abort_grant", grant, 4'b1000);
        req = 4'b1011;
        repeat (14) @(negedge clk);
        expect_done(4'b0001, 1, -1);
        req = 4'b0011;
        @(negedge clk);
        chk("abort_grant_off", grant, 0);
        chk("abort_no_done", done, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        chk("after_abort_winner", grant, 4'b0001);
        wait_done("after_abort", 20);
        req = '0;
        repeat (2) @(negedge clk);

        // Abort in the same cycle as the completing tick
        set_dly(2, 1);
        req = 4'b0100;
        repeat (10) @(negedge clk);
        chk("tp_tick", tick, 1);
        chk("tp_grant", grant, 4'b0100);
        req = '0;
        @(negedge clk);
        chk("tp_no_done", done, 0);
        chk("tp_grant_off", grant, 0);
        chk("tp_busy", busy, 0);
        repeat (2) @(negedge clk);

        // Maximum delay
        set_dly(3, 255);
        expect_done(4'b1000, 255, -1);
        req = 4'b1000;
        wait_done("maxd", 2600);
        req = '0;
        repeat (3) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
